// File: rtl/im_cfg_pkg.sv
// Shared types and constants for the imaging-config AXI4-Lite master.
// Latency: none (declarations only).
// Backpressure: not applicable.
package im_cfg_pkg;

  localparam int CFG_WORD_W = 32;
  localparam int MAX_NUM_REGS = 16;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_DONE    = 3'd5
  } im_cfg_state_t;

  // A single-entry table still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/im_cfg_table.sv
// Snapshot of the configuration words taken when a sequence starts.
// Latency: load takes effect next cycle; read port is combinational.
// Backpressure: none; load is a single-cycle strobe.
module im_cfg_table
  import im_cfg_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [CFG_WORD_W*NUM_REGS-1:0] load_dat,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [CFG_WORD_W-1:0]          rd_dat
);

  logic [CFG_WORD_W-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= load_dat[CFG_WORD_W*i +: CFG_WORD_W];
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/im_config_axil_master.sv
// AXI4-Lite master writing a NUM_REGS config table, optional read-back check (IM_CFG_READBACK_VERIFY_EN).
// Latency: 2-cycle start sync, then 2 cycles per write/read against a zero-wait slave.
// Backpressure: one outstanding transaction; VALIDs hold until READY, BREADY/RREADY only in response states.
module im_config_axil_master
  import im_cfg_pkg::*;
#(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter int                            C_M_AXI_DATA_WIDTH = 32,
  parameter int                            NUM_REGS           = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            INIT_AXI_TXN,
  input  logic [CFG_WORD_W*NUM_REGS-1:0]  cfg_data,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int              IDX_W    = idx_width(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  im_cfg_state_t state, state_nxt;

  logic                          init_r, init_q;
  logic                          start, start_acc;
  logic [IDX_W-1:0]              idx;
  logic                          last;
  logic                          aw_done, w_done;
  logic                          aw_hs, w_hs, wr_addr_ok;
  logic                          error_q;
  logic [CFG_WORD_W-1:0]         tbl_dat;
  logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr;

  // Only a fresh low-to-high transition starts a sequence, and only when idle or finished.
  assign start     = init_r & ~init_q;
  assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
  assign last      = (idx == LAST_IDX);

  assign aw_hs      = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs       = M_AXI_WVALID && M_AXI_WREADY;
  assign wr_addr_ok = (aw_done || aw_hs) && (w_done || w_hs);

  assign word_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx, 2'b00});

  im_cfg_table #(
    .NUM_REGS(NUM_REGS),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .load    (start_acc),
    .load_dat(cfg_data),
    .rd_idx  (idx),
    .rd_dat  (tbl_dat)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_WR_ADDR;
      ST_WR_ADDR:       if (wr_addr_ok) state_nxt = ST_WR_RESP;
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
`ifdef IM_CFG_READBACK_VERIFY_EN
          state_nxt = last ? ST_RD_ADDR : ST_WR_ADDR;
`else
          state_nxt = last ? ST_DONE : ST_WR_ADDR;
`endif
        end
      end
`ifdef IM_CFG_READBACK_VERIFY_EN
      ST_RD_ADDR: if (M_AXI_ARREADY) state_nxt = ST_RD_DATA;
      ST_RD_DATA: if (M_AXI_RVALID) state_nxt = last ? ST_DONE : ST_RD_ADDR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // VALIDs decode straight from state so an async reset drops them immediately.
  always_comb begin
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    TXN_DONE      = 1'b0;
    unique case (state)
      ST_WR_ADDR: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
      end
      ST_WR_RESP: M_AXI_BREADY = 1'b1;
`ifdef IM_CFG_READBACK_VERIFY_EN
      ST_RD_ADDR: M_AXI_ARVALID = 1'b1;
      ST_RD_DATA: M_AXI_RREADY  = 1'b1;
`endif
      ST_DONE:    TXN_DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      init_r  <= 1'b0;
      init_q  <= 1'b0;
      idx     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      init_r <= INIT_AXI_TXN;
      init_q <= init_r;
      if (start_acc) begin
        idx     <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        unique case (state)
          ST_WR_ADDR: begin
            if (wr_addr_ok) begin
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              aw_done <= aw_done | aw_hs;
              w_done  <= w_done | w_hs;
            end
          end
          ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
              if (M_AXI_BRESP != AXI_RESP_OKAY) error_q <= 1'b1;
              idx <= last ? '0 : idx + 1'b1;
            end
          end
`ifdef IM_CFG_READBACK_VERIFY_EN
          ST_RD_DATA: begin
            if (M_AXI_RVALID) begin
              if (M_AXI_RRESP != AXI_RESP_OKAY || M_AXI_RDATA != tbl_dat) error_q <= 1'b1;
              idx <= last ? '0 : idx + 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign ERROR        = error_q;
  assign M_AXI_AWADDR = word_addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_WDATA  = tbl_dat;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_ARPROT = 3'b000;

`ifdef IM_CFG_READBACK_VERIFY_EN
  assign M_AXI_ARADDR = word_addr;
`else
  logic unused_rd;
  assign M_AXI_ARADDR = '0;
  assign unused_rd    = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

endmodule
